// File: rtl/nor_burst_reader.sv
// NOR flash burst read engine: asynchronous read cycles with a programmable access wait.
// Optional Read-Array command phase before the burst is enabled by defining NOR_READ_ARRAY_CMD_EN.
module nor_burst_reader #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 8,
    parameter int WAIT_CYC = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [LEN_W-1:0]  LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] DATA
);

    localparam int CNT_W = $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_WAIT   = 3'd1,
        FINISH    = 3'd2
`ifdef NOR_READ_ARRAY_CMD_EN
        ,
        CMD_SETUP = 3'd3,
        CMD_PULSE = 3'd4,
        CMD_HOLD  = 3'd5,
        CMD_REC   = 3'd6
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

`ifdef NOR_READ_ARRAY_CMD_EN
    localparam logic [DATA_W-1:0] READ_ARRAY_CMD = DATA_W'(16'h00FF);
    logic cmd_drive;

    // The bus is only ever driven while OE is high (command states).
    assign DATA = cmd_drive ? READ_ARRAY_CMD : {DATA_W{1'bz}};
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        CE         = 1'b1;
        OE         = 1'b1;
        WE         = 1'b1;
        BUSY       = 1'b0;
        DONE       = 1'b0;
`ifdef NOR_READ_ARRAY_CMD_EN
        cmd_drive  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    addr_d = START_ADDR;
                    rem_d  = LEN;
                    cnt_d  = CNT_ONE;
                    if (LEN == '0) begin
                        state_d = FINISH;
                    end else begin
`ifdef NOR_READ_ARRAY_CMD_EN
                        state_d = CMD_SETUP;
`else
                        state_d = RD_WAIT;
`endif
                    end
                end
            end
`ifdef NOR_READ_ARRAY_CMD_EN
            CMD_SETUP: begin
                BUSY      = 1'b1;
                CE        = 1'b0;
                cmd_drive = 1'b1;
                cnt_d     = CNT_ONE;
                state_d   = CMD_PULSE;
            end
            CMD_PULSE: begin
                BUSY      = 1'b1;
                CE        = 1'b0;
                WE        = 1'b0;
                cmd_drive = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = CMD_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CMD_HOLD: begin
                BUSY      = 1'b1;
                CE        = 1'b0;
                cmd_drive = 1'b1;
                state_d   = CMD_REC;
            end
            CMD_REC: begin
                BUSY    = 1'b1;
                cnt_d   = CNT_ONE;
                state_d = RD_WAIT;
            end
`endif
            RD_WAIT: begin
                BUSY = 1'b1;
                CE   = 1'b0;
                OE   = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    // Sample edge: CE/OE stay low across words for back-to-back reads.
                    rd_data_d  = DATA;
                    rd_valid_d = 1'b1;
                    addr_d     = addr_q + ADDR_W'(1);
                    rem_d      = rem_q - LEN_W'(1);
                    cnt_d      = CNT_ONE;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = FINISH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FINISH: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ADDR     = addr_q;
    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;

endmodule

// File: tb/tb_nor_burst_reader.sv
// Directed bench for nor_burst_reader: table of bursts plus reset and START-collision sequences.
// Expected latencies also cover the NOR_READ_ARRAY_CMD_EN build.
module tb_nor_burst_reader;

    localparam int W = 4;
`ifdef NOR_READ_ARRAY_CMD_EN
    localparam int DONE_OFS = W + 3;
    localparam int CE_OFS   = W + 2;
    localparam int WE_EXP   = W;
`else
    localparam int DONE_OFS = 0;
    localparam int CE_OFS   = 0;
    localparam int WE_EXP   = 0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [23:0] START_ADDR = '0;
    logic [7:0]  LEN = '0;
    logic        BUSY, DONE, RD_VALID, CE, OE, WE;
    logic [15:0] RD_DATA;
    logic [23:0] ADDR;
    wire  [15:0] DATA;
    logic [15:0] xor_v = '0;

    int n_tests = 0;
    int n_fail  = 0;

    nor_burst_reader #(.ADDR_W(24), .DATA_W(16), .LEN_W(8), .WAIT_CYC(W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .START_ADDR(START_ADDR), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .CE(CE), .OE(OE), .WE(WE), .ADDR(ADDR), .DATA(DATA)
    );

    // Flash model: drives address-derived data whenever it is selected for reading.
    assign DATA = (!CE && !OE) ? (ADDR[15:0] ^ xor_v) : 16'hzzzz;

    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  len;
        logic [15:0] xr;
        int          mid;       // 0 none, 1 START mid-burst, 2 START in FINISH cycle
        int          done_c;    // DONE cycle index without command phase
        logic [15:0] last;
        logic [23:0] end_addr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ce"}, CE, 1);
        chk({tag, "_oe"}, OE, 1);
        chk({tag, "_we"}, WE, 1);
        chk({tag, "_addr"}, ADDR, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_valid"}, RD_VALID, 0);
        chk({tag, "_rd_data"}, RD_DATA, 0);
    endtask

    task automatic run_burst(input vec_t v);
        int valids = 0, busy_n = 0, ce_n = 0, oe_n = 0, we_n = 0, got_done = 0, exp_done;
        logic [23:0] e_addr;
        exp_done = v.done_c + ((v.len != 0) ? DONE_OFS : 0);
        xor_v  = v.xr;
        e_addr = v.addr;
        @(negedge CLK);
        START = 1'b1; START_ADDR = v.addr; LEN = v.len;
        @(negedge CLK);
        START = 1'b0; START_ADDR = 24'h555555; LEN = 8'h09;
        for (int c = 1; c <= 300; c++) begin
            if (c > 1) @(negedge CLK);
            if (RD_VALID) begin
                chk("rd_data", RD_DATA, e_addr[15:0] ^ v.xr);
                e_addr = e_addr + 24'd1;
                valids++;
            end
            if (!OE) begin
                oe_n++;
                chk("addr", ADDR, e_addr);
                chk("ce_with_oe", CE, 0);
            end
            if (!CE) ce_n++;
            if (!WE) begin
                we_n++;
                chk("cmd_data", DATA, 16'h00FF);
            end
            if (BUSY) busy_n++;
            if (v.mid == 1 && c == 6) START = 1'b1;
            if (v.mid == 1 && c == 7) START = 1'b0;
            if (DONE) begin
                got_done = c;
                chk("valid_with_done", RD_VALID, (v.len != 0));
                if (v.mid == 2) START = 1'b1;
                break;
            end
        end
        if (got_done == 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no DONE expected DONE at cycle %0d", exp_done);
        end
        chk("done_cycle", got_done, exp_done);
        chk("valid_count", valids, v.len);
        chk("oe_low_cycles", oe_n, W * v.len);
        chk("ce_low_cycles", ce_n, W * v.len + ((v.len != 0) ? CE_OFS : 0));
        chk("we_low_cycles", we_n, (v.len != 0) ? WE_EXP : 0);
        chk("busy_cycles", busy_n, (v.len != 0) ? exp_done - 1 : 0);
        @(negedge CLK);
        START = 1'b0;
        chk("post_busy", BUSY, 0);
        chk("post_done", DONE, 0);
        chk("post_ce", CE, 1);
        chk("post_oe", OE, 1);
        chk("post_rd_data", RD_DATA, v.last);
        chk("post_addr", ADDR, v.end_addr);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{24'h3F0002, 8'd1, 16'hA558, 0, 5,  16'hA55A, 24'h3F0003};
        vecs[1] = '{24'h000010, 8'd4, 16'h0000, 0, 17, 16'h0013, 24'h000014};
        vecs[2] = '{24'hFFFFFE, 8'd3, 16'h0000, 1, 13, 16'h0000, 24'h000001};
        vecs[3] = '{24'h123456, 8'd0, 16'h0000, 0, 1,  16'h0000, 24'h123456};
        vecs[4] = '{24'h00ABCD, 8'd2, 16'h1111, 2, 9,  16'hBADF, 24'h00ABCF};

        #12;
        check_reset_outputs("reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_busy", BUSY, 0);

        for (int i = 0; i < 5; i++) run_burst(vecs[i]);

        // Asynchronous reset in the middle of a long burst.
        xor_v = 16'h0000;
        @(negedge CLK);
        START = 1'b1; START_ADDR = 24'h000100; LEN = 8'd8;
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        chk("pre_reset_busy", BUSY, 1);
        #2 RESET_N = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge CLK);
        check_reset_outputs("held_reset");
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("after_reset_done", DONE, 0);
        run_burst('{24'h000200, 8'd2, 16'h0000, 0, 9, 16'h0201, 24'h000202});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/nor_burst_reader.md
Name: nor_burst_reader

Overview:
- Parametrised NOR flash read engine. Accepts a start address and a word count, runs asynchronous read cycles on the flash bus with a programmable access wait, and streams each word out with a valid strobe.
- Sits between the flash pins (CE/OE/WE/ADDR/DATA) and user logic, such as a display or loader.
- Optionally issues a Read-Array command (0x00FF) before the burst.

Parameters:
- ADDR_W, 24, flash word-address width.
- DATA_W, 16, flash data bus width.
- LEN_W, 8, width of the word-count input.
- WAIT_CYC, 4, CLK cycles from address/OE valid to data sample. Legal range is 2 or more.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- START_ADDR  input  ADDR_W  first word address, captured with START.
- LEN  input  LEN_W  number of words to read, captured with START.
- BUSY  output  1  high while a transaction is in progress.
- DONE  output  1  one-cycle completion pulse.
- RD_DATA  output  DATA_W  last sampled word; held until the next sample.
- RD_VALID  output  1  one-cycle strobe; RD_DATA is new in this cycle.
- CE  output  1  flash chip enable, active low.
- OE  output  1  flash output enable, active low.
- WE  output  1  flash write enable, active low.
- ADDR  output  ADDR_W  flash address.
- DATA  inout  DATA_W  flash data bus; high-Z except during the command phase.

Behaviour:
- Reset (asynchronous, RESET_N=0), including mid-transaction:
  - CE=OE=WE=1, ADDR=0, DATA released to high-Z.
  - BUSY=DONE=RD_VALID=0, RD_DATA=0.
  - State goes to IDLE and the internal counters clear.
  - No partial DONE is produced.
- States: IDLE, CMD_SETUP, CMD_PULSE, CMD_HOLD, CMD_REC, RD_WAIT, FINISH. The CMD_* states exist only with the macro.
- IDLE:
  - CE/OE/WE are high and DATA is high-Z.
  - START=1 captures START_ADDR into the address register and LEN into the remaining-count register.
  - If LEN=0, go to FINISH: no bus activity, DONE pulses on the next cycle.
  - Otherwise go to RD_WAIT, or to CMD_SETUP with the macro. BUSY rises on the same edge.
- RD_WAIT:
  - CE=0, OE=0, WE=1, ADDR = current address.
  - The wait counter counts 1..WAIT_CYC. On the edge where the counter equals WAIT_CYC:
    - DATA is sampled into RD_DATA and RD_VALID=1 for the following cycle.
    - The address increments modulo 2^ADDR_W, so 0xFFFFFF is followed by 0x000000.
    - The remaining count decrements.
    - If the remaining count was 1, go to FINISH. Otherwise the counter restarts, RD_WAIT continues, and CE/OE stay low (back-to-back words).
- Throughput: one word per WAIT_CYC cycles.
- Latency without the macro: first RD_VALID occurs WAIT_CYC+1 cycles after the START edge.
- FINISH:
  - CE=OE=1, BUSY=0, DONE=1 for exactly one cycle. DONE coincides with the final RD_VALID.
  - Next state is IDLE. A START in the FINISH cycle is ignored.
- START while BUSY=1 is ignored, and START_ADDR/LEN changes have no effect during a transaction.
- WE is never low outside CMD_PULSE.
- DATA is never driven while OE=0.

Optional Feature:
- Macro: NOR_READ_ARRAY_CMD_EN.
- Defined: after START, and only when LEN≠0, the block runs a command phase before the burst:
  - CMD_SETUP (1 cycle): CE=0, WE=1, OE=1, ADDR=START_ADDR, DATA driven 0x00FF (zero-extended to DATA_W).
  - CMD_PULSE (WAIT_CYC cycles): WE=0, data still driven.
  - CMD_HOLD (1 cycle): WE=1, data still driven.
  - CMD_REC (1 cycle): CE=1, DATA high-Z.
  - Then RD_WAIT. First RD_VALID occurs at 2·WAIT_CYC+4 cycles after START.
- Undefined: the CMD_* states, the 0x00FF constant and the DATA drive logic are absent. DATA is a permanent input and the first RD_VALID occurs at WAIT_CYC+1.

Test Plan:
- WAIT_CYC=4, START_ADDR=0x3F0002, LEN=1, flash model returns 0xA55A:
  - CE/OE low for 4 cycles, RD_DATA=0xA55A.
  - RD_VALID and DONE pulse together 5 cycles after START.
  - BUSY=1 for 4 cycles.
- START_ADDR=0x000010, LEN=4, model data = address low 16 bits:
  - ADDR steps 0x10..0x13 every 4 cycles.
  - RD_DATA sequence 0x0010..0x0013, four RD_VALID pulses, DONE on the 4th.
- Wrap and START while busy:
  - START_ADDR=0xFFFFFE, LEN=3: ADDR sequence 0xFFFFFE, 0xFFFFFF, 0x000000.
  - A second START issued mid-burst has no effect.
- LEN=0:
  - CE/OE/WE remain high.
  - DONE pulses 1 cycle after START, with no RD_VALID.
- Reset mid-burst:
  - Assert RESET_N=0 during the 2nd word of LEN=8. All outputs go to reset values immediately, without waiting for a CLK edge.
  - After release, START with LEN=2 completes normally.
- With NOR_READ_ARRAY_CMD_EN:
  - START, LEN=1: DATA=0x00FF while WE is low for 4 cycles.
  - DATA is high-Z before OE falls; RD_VALID occurs at cycle 12.
